setup_menu_param: RTL and testbench
===================================

// Module: setup_menu_param
// PURPOSE
//  Parametrised lock-configuration menu, successor of the fixed 4-PIN setup FSM.
//  - Takes raw keypad codes directly and walks an operator through a field list:
//    beep on/off, beep time, auto-lock time, then NUM_PINS user PINs of PIN_DIGITS digits.
//  - Drives the 6-digit BCD display and commits a new config word to the lock core on finish.
//  - Adds BACK, ESC abort and an inactivity timeout.
// PARAMETERS
//  NUM_PINS     4          number of PIN slots, 1..8; PIN 1 is always enabled
//  PIN_DIGITS   4          digits per PIN, 1..4
//  T_MIN        5          lower clamp for both time fields, seconds
//  T_MAX        60         upper clamp for both time fields, seconds, <=99
//  TIMEOUT_CYC  50_000_000 idle cycles before automatic abort; 0 disables timeout
// PORTS
//  clk         in   1     clock
//  rst         in   1     reset, asynchronous, active-high
//  key_valid   in   1     one-cycle strobe, key_code valid
//  key_code    in   4     0-9 digit; A=ENTER; C=BACK; F=ESC; others ignored
//  setup_on    in   1     level request from lock core to enter setup
//  cfg_in      in   CW    current config; CW = 15 + NUM_PINS*(1+4*PIN_DIGITS)
//  cfg_out     out  CW    committed config
//  cfg_wr      out  1     one-cycle strobe, cfg_out updated this cycle
//  setup_busy  out  1     high from LOAD until WAIT_REL exit
//  setup_abort out  1     one-cycle strobe, session ended without commit
//  disp_out    out  24    BCD5..BCD0 (BCD5 = [23:20]); 4'hB = blank
//  disp_en     out  1     display ownership, high while in EDIT
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0, except disp_out = 24'hBBBBBB.
//  cfg word LSB first:
//   - [0] beep_on; [7:1] beep_time; [14:8] lock_time
//   - then per PIN k=0..NUM_PINS-1: status bit, then PIN_DIGITS BCD nibbles, first digit lowest
//  Field list, step numbers 1..NSTEP:
//   - 1 beep_on; 2 beep_time; 3 lock_time; 4 PIN1 digits
//   - for k>=1: PIN(k+1) status, then PIN(k+1) digits
//   - NSTEP = 2*NUM_PINS+2
//  FSM:
//   - IDLE: setup_on=1 -> LOAD.
//   - LOAD (1 cyc): working copy <= cfg_in; PIN1 status forced 1; step=1; -> EDIT.
//   - EDIT: entry buffer preloaded with the field value on every step entry.
//     - digit key: shift buffer left one nibble, new digit in BCD0.
//       Buffer width: 1 for 0/1 fields, 2 for time fields, PIN_DIGITS for PINs.
//     - ENTER, 0/1 field: value >1 -> ignored, stay; else write and advance.
//     - ENTER, time field: v = 10*BCD1 + BCD0; stored = clamp(v, T_MIN, T_MAX), 7 bits; advance.
//     - ENTER, PIN digits: write and advance.
//     - Status field written 0 -> skip that PIN's digits step.
//     - BACK: discard buffer, go to previous step, skipping disabled PIN digit steps;
//       BACK at step 1 is ignored.
//     - ESC -> ABORT.
//     - ENTER on the last reachable step -> COMMIT.
//   - COMMIT (1 cyc): cfg_out <= working copy; cfg_wr=1; -> WAIT_REL.
//   - ABORT (1 cyc): setup_abort=1; cfg_out unchanged; -> WAIT_REL.
//   - WAIT_REL: disp_en=0; wait setup_on=0 -> IDLE, where setup_busy drops.
//  Display in EDIT, registered, updated the cycle after any key:
//   - BCD5:BCD4 = step number, decimal.
//   - BCD3..BCD0 = buffer right-aligned, unused positions 4'hB.
//  Timeout:
//   - Counter cleared on LOAD and on every key_valid in EDIT.
//   - Reaching TIMEOUT_CYC-1 with no key -> ABORT.
//  Precedence and boundaries:
//   - A key arriving in the same cycle as the timeout is accepted; the timeout does not fire.
//   - setup_on dropping during EDIT -> ABORT.
//   - Keys outside EDIT are ignored.
//   - rst mid-session: immediate return to IDLE; no cfg_wr.
//  Latency:
//   - setup_on rise -> disp_en high 2 cycles later.
//   - final ENTER -> cfg_wr on the next cycle.
// TESTING
//  T1 full pass, defaults:
//   - cfg_in beep_time=10, PINs 1234 / off / off / off.
//   - Keys A,A,A,A,A,A,A -> cfg_wr once; cfg_out == cfg_in except PIN1 status=1.
//  T2 clamp:
//   - Step 2, keys 7,5,A -> beep_time=60.
//   - Step 3, keys 0,2,A -> lock_time=5.
//   - Keys 9,9,0,A -> 90 -> 60.
//  T3 0/1 check and skip:
//   - Step 1, keys 7,A -> stays at step 1; display BCD0=7.
//   - PIN2 status 0 then A -> next display step is PIN3 status, skipping PIN2 digits.
//  T4 BACK:
//   - At step 3, key C -> step 2 shown with stored beep_time.
//   - C at step 1 -> no change.
//  T5 abort paths:
//   - ESC mid-menu -> setup_abort pulse, cfg_wr never asserted.
//   - TIMEOUT_CYC=20: no key for 20 cycles -> abort.
//   - Key on cycle 19 -> no abort.
//  T6 params and reset:
//   - NUM_PINS=2, PIN_DIGITS=3: NSTEP=6, PIN fields show blank in BCD3.
//   - rst asserted mid-EDIT -> outputs return to reset values, state IDLE.

Source files
------------

// File: rtl/setup_menu_param_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : setup_menu_param_if                                             |
// | Brief    : Keypad, lock-core and display signals of the setup menu.        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface setup_menu_param_if #(
  parameter int CW = 83
) ();
  logic          key_valid;
  logic [3:0]    key_code;
  logic          setup_on;
  logic [CW-1:0] cfg_in;
  logic [CW-1:0] cfg_out;
  logic          cfg_wr;
  logic          setup_busy;
  logic          setup_abort;
  logic [23:0]   disp_out;
  logic          disp_en;

  modport slave (
    input  key_valid, key_code, setup_on, cfg_in,
    output cfg_out, cfg_wr, setup_busy, setup_abort, disp_out, disp_en
  );

  modport master (
    output key_valid, key_code, setup_on, cfg_in,
    input  cfg_out, cfg_wr, setup_busy, setup_abort, disp_out, disp_en
  );
endinterface
`default_nettype wire

// File: rtl/setup_menu_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : setup_menu_param                                                |
// | Brief    : Parametrised lock configuration menu: walks the operator        |
// |            through beep, time and PIN fields and commits a config word.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module setup_menu_param #(
  parameter int          NUM_PINS    = 4,
  parameter int          PIN_DIGITS  = 4,
  parameter int          T_MIN       = 5,
  parameter int          T_MAX       = 60,
  parameter int unsigned TIMEOUT_CYC = 50_000_000
) (
  input wire logic        clk,
  input wire logic        rst,
  setup_menu_param_if.slave bus
);
  localparam int          PIN_W    = 1 + 4*PIN_DIGITS;
  localparam int          CW       = 15 + NUM_PINS*PIN_W;
  localparam logic [4:0]  C_NSTEP  = 5'(2*NUM_PINS + 2);
  localparam logic [7:0]  C_TMIN   = 8'(T_MIN);
  localparam logic [7:0]  C_TMAX   = 8'(T_MAX);
  localparam logic [31:0] C_TO_END = (TIMEOUT_CYC > 0) ? 32'(TIMEOUT_CYC - 1) : 32'd0;
  localparam logic [15:0] C_PMASK  = 16'((32'h1 << (4*PIN_DIGITS)) - 1);
  localparam logic [1:0]  K_BIT = 2'd0, K_TIME = 2'd1, K_PIN = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_EDIT, S_COMMIT, S_ABORT, S_WAIT_REL
  } state_t;

  state_t        state_q, state_d;
  logic [4:0]    step_q, step_d;
  logic [15:0]   buf_q, buf_d;
  logic [CW-1:0] work_q, work_d;
  logic [31:0]   cnt_q, cnt_d;
  logic [CW-1:0] cfg_out_q;
  logic [23:0]   disp_q;
  logic [4:0]    w_next, w_prev;

  // Step 4 is PIN1 digits; from step 5 on, odd steps are PIN status, even are digits.
  function automatic int pin_idx(input logic [4:0] s);
    return (int'(s) - 3) / 2;
  endfunction

  function automatic logic [1:0] fkind(input logic [4:0] s);
    if (s == 5'd1)                return K_BIT;
    if (s == 5'd2 || s == 5'd3)   return K_TIME;
    if (!s[0])                    return K_PIN;
    return K_BIT;
  endfunction

  // Nibbles of the entry buffer that belong to the field at step s.
  function automatic logic [15:0] fmask(input logic [4:0] s);
    logic [15:0] m;
    m = 16'h000F;
    if (fkind(s) == K_TIME)     m = 16'h00FF;
    else if (fkind(s) == K_PIN) m = C_PMASK;
    return m;
  endfunction

  function automatic logic [7:0] to_bcd(input logic [6:0] v);
    return {4'((v / 7'd10) % 7'd10), 4'(v % 7'd10)};
  endfunction

  function automatic logic [6:0] clamp_t(input logic [7:0] b);
    logic [7:0] v;
    v = 8'(b[7:4]) * 8'd10 + 8'(b[3:0]);
    if (v < C_TMIN)      v = C_TMIN;
    else if (v > C_TMAX) v = C_TMAX;
    return 7'(v);
  endfunction

  function automatic logic status_of(input logic [4:0] s, input logic [CW-1:0] w);
    logic st;
    st = 1'b0;
    for (int k = 0; k < NUM_PINS; k++)
      if (k == pin_idx(s)) st = w[15 + k*PIN_W];
    return st;
  endfunction

  // Entry buffer contents for a field; first PIN digit lands in the leftmost position.
  function automatic logic [15:0] preload(input logic [4:0] s, input logic [CW-1:0] w);
    logic [15:0] r;
    r = '0;
    if (s == 5'd1)      r[0]   = w[0];
    else if (s == 5'd2) r[7:0] = to_bcd(w[7:1]);
    else if (s == 5'd3) r[7:0] = to_bcd(w[14:8]);
    else begin
      for (int k = 0; k < NUM_PINS; k++) begin
        if (k == pin_idx(s)) begin
          if (s[0]) r[0] = w[15 + k*PIN_W];
          else
            for (int j = 0; j < PIN_DIGITS; j++)
              r[4*(PIN_DIGITS-1-j) +: 4] = w[15 + k*PIN_W + 1 + 4*j +: 4];
        end
      end
    end
    return r;
  endfunction

  function automatic logic [CW-1:0] store(input logic [4:0] s, input logic [CW-1:0] w,
                                          input logic [15:0] b);
    logic [CW-1:0] r;
    r = w;
    if (s == 5'd1)      r[0]    = b[0];
    else if (s == 5'd2) r[7:1]  = clamp_t(b[7:0]);
    else if (s == 5'd3) r[14:8] = clamp_t(b[7:0]);
    else begin
      for (int k = 0; k < NUM_PINS; k++) begin
        if (k == pin_idx(s)) begin
          if (s[0]) r[15 + k*PIN_W] = b[0];
          else
            for (int j = 0; j < PIN_DIGITS; j++)
              r[15 + k*PIN_W + 1 + 4*j +: 4] = b[4*(PIN_DIGITS-1-j) +: 4];
        end
      end
    end
    return r;
  endfunction

  function automatic logic [23:0] disp_of(input logic [4:0] s, input logic [15:0] b);
    logic [23:0] d;
    logic [15:0] m;
    m         = fmask(s);
    d[23:20]  = (s >= 5'd10) ? 4'd1 : 4'd0;
    d[19:16]  = (s >= 5'd10) ? 4'(s - 5'd10) : 4'(s);
    for (int i = 0; i < 4; i++)
      d[4*i +: 4] = m[4*i] ? b[4*i +: 4] : 4'hB;
    return d;
  endfunction

  // Session state, step, entry buffer, working copy and inactivity counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      step_q  <= 5'd1;
      buf_q   <= '0;
      work_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      buf_q   <= buf_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
    end
  end

  // Menu sequencing: key decode, field write-back, skip/back navigation, aborts.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    buf_d   = buf_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    w_next  = step_q + 5'd1;
    w_prev  = step_q - 5'd1;
    case (state_q)
      S_IDLE: if (bus.setup_on) state_d = S_LOAD;
      S_LOAD: begin
        work_d     = bus.cfg_in;
        work_d[15] = 1'b1;
        step_d     = 5'd1;
        buf_d      = preload(5'd1, work_d);
        cnt_d      = '0;
        state_d    = S_EDIT;
      end
      S_EDIT: begin
        if (!bus.setup_on) begin
          state_d = S_ABORT;
        end else if (bus.key_valid) begin
          cnt_d = '0;
          if (bus.key_code <= 4'd9) begin
            buf_d = {buf_q[11:0], bus.key_code} & fmask(step_q);
          end else if (bus.key_code == 4'hA) begin
            if (fkind(step_q) != K_BIT || buf_q[3:0] <= 4'd1) begin
              work_d = store(step_q, work_q, buf_q);
              if (w_next <= C_NSTEP && !w_next[0] && w_next >= 5'd6 && !status_of(w_next, work_d))
                w_next = w_next + 5'd1;
              if (w_next > C_NSTEP) begin
                state_d = S_COMMIT;
              end else begin
                step_d = w_next;
                buf_d  = preload(w_next, work_d);
              end
            end
          end else if (bus.key_code == 4'hC) begin
            if (step_q != 5'd1) begin
              if (!w_prev[0] && w_prev >= 5'd6 && !status_of(w_prev, work_q))
                w_prev = w_prev - 5'd1;
              step_d = w_prev;
              buf_d  = preload(w_prev, work_q);
            end
          end else if (bus.key_code == 4'hF) begin
            state_d = S_ABORT;
          end
        end else if (TIMEOUT_CYC != 0 && cnt_q == C_TO_END) begin
          state_d = S_ABORT;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_COMMIT, S_ABORT: state_d = S_WAIT_REL;
      S_WAIT_REL: if (!bus.setup_on) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Committed word and the registered display image of the next edit state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_out_q <= '0;
      disp_q    <= 24'hBBBBBB;
    end else begin
      if (state_d == S_COMMIT) cfg_out_q <= work_d;
      disp_q <= (state_d == S_EDIT) ? disp_of(step_d, buf_d) : 24'hBBBBBB;
    end
  end

  assign bus.cfg_out     = cfg_out_q;
  assign bus.cfg_wr      = (state_q == S_COMMIT);
  assign bus.setup_abort = (state_q == S_ABORT);
  assign bus.setup_busy  = (state_q != S_IDLE);
  assign bus.disp_en     = (state_q == S_EDIT);
  assign bus.disp_out    = disp_q;
endmodule
`default_nettype wire

// File: tb/tb_setup_menu_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_setup_menu_param                                             |
// | Brief    : Scoreboard bench for setup_menu_param, two parameter sets.      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_setup_menu_param;
  localparam int CWA = 83;   // NUM_PINS=4, PIN_DIGITS=4
  localparam int CWB = 41;   // NUM_PINS=2, PIN_DIGITS=3

  typedef struct {
    bit              commit;
    logic [CWA-1:0]  cfg;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [23:0] q_da[$];
  logic [23:0] q_db[$];
  ev_t         q_ea[$];
  ev_t         q_eb[$];
  ev_t         ev_a, ev_b;
  logic        seen_a = 1'b0, seen_b = 1'b0;

  logic [CWA-1:0] cfg_a, exp1, exp2;
  logic [CWB-1:0] cfg_b, expb;

  // Session 2 table: {key, display expected after the key}.
  logic [27:0] seq2 [31] = '{
    {4'hC, 24'h01BBB1}, {4'h7, 24'h01BBB7}, {4'hA, 24'h01BBB7}, {4'h1, 24'h01BBB1},
    {4'hA, 24'h02BB10}, {4'h7, 24'h02BB07}, {4'h5, 24'h02BB75}, {4'hA, 24'h03BB30},
    {4'hC, 24'h02BB60}, {4'hA, 24'h03BB30}, {4'h0, 24'h03BB00}, {4'h2, 24'h03BB02},
    {4'hA, 24'h041234}, {4'hC, 24'h03BB05}, {4'h9, 24'h03BB59}, {4'h9, 24'h03BB99},
    {4'h0, 24'h03BB90}, {4'hA, 24'h041234}, {4'h5, 24'h042345}, {4'h6, 24'h043456},
    {4'h7, 24'h044567}, {4'h8, 24'h045678}, {4'hA, 24'h05BBB0}, {4'h1, 24'h05BBB1},
    {4'hA, 24'h060000}, {4'hC, 24'h05BBB1}, {4'h0, 24'h05BBB0}, {4'hA, 24'h07BBB0},
    {4'hC, 24'h05BBB0}, {4'hA, 24'h07BBB0}, {4'hA, 24'h09BBB0}
  };

  setup_menu_param_if #(.CW(CWA)) if_a ();
  setup_menu_param_if #(.CW(CWB)) if_b ();

  setup_menu_param #(.NUM_PINS(4), .PIN_DIGITS(4), .T_MIN(5), .T_MAX(60), .TIMEOUT_CYC(20))
    dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
  setup_menu_param #(.NUM_PINS(2), .PIN_DIGITS(3), .T_MIN(5), .T_MAX(60), .TIMEOUT_CYC(0))
    dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic miss(input string nm);
    n_checks++;
    n_errors++;
    $display("FAIL %s actual=unexpected-output required=none", nm);
  endtask

  always @(posedge clk) begin
    seen_a <= if_a.key_valid;
    seen_b <= if_b.key_valid;
  end

  // Monitor A: pops a display entry after each key, an event on each strobe.
  always @(negedge clk) begin
    if (seen_a) begin
      if (q_da.size() == 0) miss("disp_a_extra");
      else chk("disp_a", if_a.disp_out, q_da.pop_front());
    end
    if (if_a.cfg_wr || if_a.setup_abort) begin
      if (q_ea.size() == 0) miss("evt_a_extra");
      else begin
        ev_a = q_ea.pop_front();
        chk("evt_a_kind", {if_a.cfg_wr, if_a.setup_abort}, ev_a.commit ? 2'b10 : 2'b01);
        if (ev_a.commit) chk("cfg_a", if_a.cfg_out, ev_a.cfg);
      end
    end
  end

  // Monitor B.
  always @(negedge clk) begin
    if (seen_b) begin
      if (q_db.size() == 0) miss("disp_b_extra");
      else chk("disp_b", if_b.disp_out, q_db.pop_front());
    end
    if (if_b.cfg_wr || if_b.setup_abort) begin
      if (q_eb.size() == 0) miss("evt_b_extra");
      else begin
        ev_b = q_eb.pop_front();
        chk("evt_b_kind", {if_b.cfg_wr, if_b.setup_abort}, ev_b.commit ? 2'b10 : 2'b01);
        if (ev_b.commit) chk("cfg_b", if_b.cfg_out, ev_b.cfg);
      end
    end
  end

  // Caller is aligned to a negedge; the key is held for exactly one clock.
  task automatic press(input int which, input logic [3:0] k, input logic [23:0] d);
    if (which == 0) begin
      q_da.push_back(d);
      if_a.key_code = k; if_a.key_valid = 1'b1;
      @(negedge clk);
      if_a.key_valid = 1'b0;
    end else begin
      q_db.push_back(d);
      if_b.key_code = k; if_b.key_valid = 1'b1;
      @(negedge clk);
      if_b.key_valid = 1'b0;
    end
  endtask

  task automatic enter(input int which, input logic [23:0] d0);
    int n;
    n = 0;
    if (which == 0) if_a.setup_on = 1'b1; else if_b.setup_on = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (((which == 0) ? !if_a.disp_en : !if_b.disp_en) && n < 10);
    chk("enter_latency", 32'(n), 32'd2);
    chk("enter_disp", (which == 0) ? if_a.disp_out : if_b.disp_out, d0);
  endtask

  task automatic leave(input int which);
    if (which == 0) if_a.setup_on = 1'b0; else if_b.setup_on = 1'b0;
    repeat (3) @(negedge clk);
    chk("busy_low", (which == 0) ? if_a.setup_busy : if_b.setup_busy, 1'b0);
  endtask

  initial begin
    if_a.key_valid = 1'b0; if_a.key_code = 4'h0; if_a.setup_on = 1'b0;
    if_b.key_valid = 1'b0; if_b.key_code = 4'h0; if_b.setup_on = 1'b0;

    cfg_a = '0;
    cfg_a[0] = 1'b1; cfg_a[7:1] = 7'd10; cfg_a[14:8] = 7'd30; cfg_a[31:16] = 16'h4321;
    exp1 = cfg_a; exp1[15] = 1'b1;
    exp2 = '0;
    exp2[0] = 1'b1; exp2[7:1] = 7'd60; exp2[14:8] = 7'd60; exp2[15] = 1'b1;
    exp2[31:16] = 16'h8765;
    cfg_b = '0;
    cfg_b[7:1] = 7'd99; cfg_b[14:8] = 7'd3; cfg_b[15] = 1'b1; cfg_b[27:16] = 12'h789;
    cfg_b[28] = 1'b1; cfg_b[40:29] = 12'h654;
    expb = cfg_b; expb[7:1] = 7'd60; expb[14:8] = 7'd5;
    if_a.cfg_in = cfg_a;
    if_b.cfg_in = cfg_b;

    // Reset values.
    repeat (2) @(negedge clk);
    chk("rst_disp", if_a.disp_out, 24'hBBBBBB);
    chk("rst_flags", {if_a.cfg_wr, if_a.setup_busy, if_a.setup_abort, if_a.disp_en}, 4'b0000);
    chk("rst_cfg", if_a.cfg_out, '0);
    rst = 1'b0;
    @(negedge clk);

    // Full pass with defaults.
    enter(0, 24'h01BBB1);
    press(0, 4'hA, 24'h02BB10);
    press(0, 4'hA, 24'h03BB30);
    press(0, 4'hA, 24'h041234);
    press(0, 4'hA, 24'h05BBB0);
    press(0, 4'hA, 24'h07BBB0);
    press(0, 4'hA, 24'h09BBB0);
    q_ea.push_back('{1'b1, exp1});
    press(0, 4'hA, 24'hBBBBBB);
    chk("commit_latency", if_a.cfg_wr, 1'b1);
    leave(0);

    // Clamp, 0/1 check, BACK, status skip.
    enter(0, 24'h01BBB1);
    for (int i = 0; i < 31; i++) press(0, seq2[i][27:24], seq2[i][23:0]);
    q_ea.push_back('{1'b1, exp2});
    press(0, 4'hA, 24'hBBBBBB);
    leave(0);

    // ESC mid-menu.
    enter(0, 24'h01BBB1);
    press(0, 4'hA, 24'h02BB10);
    q_ea.push_back('{1'b0, '0});
    press(0, 4'hF, 24'hBBBBBB);
    leave(0);

    // Timeout after 20 idle cycles.
    enter(0, 24'h01BBB1);
    q_ea.push_back('{1'b0, '0});
    repeat (19) @(negedge clk);
    chk("to_cycle19_edit", if_a.disp_en, 1'b1);
    @(negedge clk);
    chk("to_cycle20_abort", if_a.setup_abort, 1'b1);
    leave(0);

    // Key on the timeout cycle wins.
    enter(0, 24'h01BBB1);
    repeat (19) @(negedge clk);
    press(0, 4'hB, 24'h01BBB1);
    chk("key_beats_to", {if_a.setup_abort, if_a.disp_en}, 2'b01);
    q_ea.push_back('{1'b0, '0});
    press(0, 4'hF, 24'hBBBBBB);
    leave(0);

    // setup_on drop during EDIT.
    enter(0, 24'h01BBB1);
    q_ea.push_back('{1'b0, '0});
    leave(0);

    // Second parameter set: 2 PINs of 3 digits, timeout disabled.
    enter(1, 24'h01BBB0);
    press(1, 4'hA, 24'h02BB99);
    press(1, 4'hA, 24'h03BB03);
    press(1, 4'hA, 24'h04B987);
    press(1, 4'hA, 24'h05BBB1);
    press(1, 4'hA, 24'h06B456);
    q_eb.push_back('{1'b1, CWA'(expb)});
    press(1, 4'hA, 24'hBBBBBB);
    leave(1);

    // Reset mid-EDIT.
    enter(0, 24'h01BBB1);
    press(0, 4'h7, 24'h01BBB7);
    @(negedge clk);
    rst = 1'b1;
    if_a.setup_on = 1'b0;
    #1;
    chk("rst_mid_disp", if_a.disp_out, 24'hBBBBBB);
    chk("rst_mid_flags", {if_a.cfg_wr, if_a.setup_busy, if_a.setup_abort, if_a.disp_en}, 4'b0000);
    chk("rst_mid_cfg", if_a.cfg_out, '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", {if_a.setup_busy, if_a.disp_en}, 2'b00);

    repeat (3) @(negedge clk);
    chk("sb_a_empty", 32'(q_da.size() + q_ea.size()), 32'd0);
    chk("sb_b_empty", 32'(q_db.size() + q_eb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
